bim_ctr_ctrl: RTL and testbench

BIM_CTR_CTRL -- requirements
Module: bim_ctr_ctrl

---
 rtl/bim_ctr_ctrl_if.sv | 34 +++
 rtl/bim_ctr_ctrl.sv | 135 +++++++++++++
 tb/tb_bim_ctr_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bim_ctr_ctrl_if.sv
// Handshake, response and SRAM-port bundle for the bimodal counter table controller.
// The master side is the client that also hosts the table SRAM.
interface bim_ctr_ctrl_if;
  logic       flush;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_idx;
  logic       resp_valid;
  logic [1:0] resp_ctr;
  logic       resp_taken;
  logic       upd_valid;
  logic       upd_ready;
  logic [7:0] upd_idx;
  logic       upd_taken;
  logic       init_done;
  logic       sram_en;
  logic       sram_wmode;
  logic [7:0] sram_addr;
  logic       sram_wmask;
  logic [1:0] sram_wdata;
  logic [1:0] sram_rdata;

  modport master (
    output flush, req_valid, req_idx, upd_valid, upd_idx, upd_taken, sram_rdata,
    input  req_ready, resp_valid, resp_ctr, resp_taken, upd_ready, init_done,
           sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
  );

  modport slave (
    input  flush, req_valid, req_idx, upd_valid, upd_idx, upd_taken, sram_rdata,
    output req_ready, resp_valid, resp_ctr, resp_taken, upd_ready, init_done,
           sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
  );
endinterface

// File: rtl/bim_ctr_ctrl.sv
// Bimodal 2-bit counter table controller: init sweep, single-port lookups and
// read-modify-write saturating updates over an attached 256x2 SRAM.
module bim_ctr_ctrl #(
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic           clock,
  input  logic           reset_n,
  bim_ctr_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;

  state_t     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic       prio_q, prio_d;
  logic       resp_valid_q, resp_valid_d;
  logic       init_done_q, init_done_d;
  logic [7:0] uidx_q, uidx_d;
  logic       utaken_q, utaken_d;

  logic       req_ready_c, upd_ready_c;
  logic       en_c, wmode_c;
  logic [7:0] addr_c;
  logic [1:0] wdata_c;

  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) res = (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       res = (ctr == 2'b00) ? ctr : ctr - 2'd1;
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    prio_d      = prio_q;
    uidx_d      = uidx_q;
    utaken_d    = utaken_q;
    req_ready_c = 1'b0;
    upd_ready_c = 1'b0;
    en_c        = 1'b0;
    wmode_c     = 1'b0;
    addr_c      = 8'h00;
    wdata_c     = 2'b00;
    unique case (state_q)
      INIT: begin
        en_c    = 1'b1;
        wmode_c = 1'b1;
        addr_c  = ptr_q;
        wdata_c = INIT_CTR;
        prio_d  = 1'b0;
        if (bus.flush) begin
          ptr_d = 8'h00;
        end else begin
          ptr_d = ptr_q + 8'd1;
          if (ptr_q == 8'hFF) state_d = IDLE;
        end
      end
      IDLE: begin
        prio_d = 1'b0;
        if (bus.flush) begin
          state_d = INIT;
          ptr_d   = 8'h00;
        end else begin
          // Right after an update's write the lookup side gets one turn, so
          // neither requester can starve the other.
          upd_ready_c = bus.upd_valid && !(prio_q && bus.req_valid);
          req_ready_c = !upd_ready_c;
          if (upd_ready_c) begin
            en_c     = 1'b1;
            addr_c   = bus.upd_idx;
            uidx_d   = bus.upd_idx;
            utaken_d = bus.upd_taken;
            state_d  = UPD_WR;
          end else if (bus.req_valid) begin
            en_c   = 1'b1;
            addr_c = bus.req_idx;
          end
        end
      end
      UPD_WR: begin
        en_c    = 1'b1;
        wmode_c = 1'b1;
        addr_c  = uidx_q;
        wdata_c = sat_ctr(bus.sram_rdata, utaken_q);
        if (bus.flush) begin
          state_d = INIT;
          ptr_d   = 8'h00;
        end else begin
          state_d = IDLE;
          prio_d  = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
    resp_valid_d = req_ready_c && bus.req_valid;
    init_done_d  = (state_d != INIT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT;
      ptr_q        <= 8'h00;
      prio_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      prio_q       <= prio_d;
      resp_valid_q <= resp_valid_d;
      init_done_q  <= init_done_d;
    end
  end

  always_ff @(posedge clock) begin
    uidx_q   <= uidx_d;
    utaken_q <= utaken_d;
  end

  // SRAM strobes are gated by reset_n so an assertion kills any write in the same cycle.
  assign bus.sram_en    = en_c & reset_n;
  assign bus.sram_wmode = wmode_c & reset_n;
  assign bus.sram_wmask = en_c & wmode_c & reset_n;
  assign bus.sram_wdata = reset_n ? wdata_c : 2'b00;
  assign bus.sram_addr  = addr_c;

  assign bus.req_ready  = req_ready_c;
  assign bus.upd_ready  = upd_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ctr   = resp_valid_q ? bus.sram_rdata : 2'b00;
  assign bus.resp_taken = bus.resp_ctr[1];
  assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_bim_ctr_ctrl.sv
// Directed bench for bim_ctr_ctrl: vector table of lookups/updates plus
// hand-written sequences for arbitration, flush and reset corner cases.
module tb_bim_ctr_ctrl;

  localparam logic [1:0] INIT_CTR = 2'b01;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  bim_ctr_ctrl_if bus ();

  bim_ctr_ctrl #(.INIT_CTR(INIT_CTR)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural 256x2 SRAM with one-cycle read latency.
  logic [1:0] mem [256];
  always @(posedge clock) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) mem[bus.sram_addr] <= bus.sram_wdata;
      else                bus.sram_rdata     <= mem[bus.sram_addr];
    end
  end

  typedef struct {
    bit         is_upd;
    logic [7:0] idx;
    bit         tk;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_next(input logic [1:0] c, input bit t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  // Caller must be at a sample point; expects the sweep to start at address 0.
  task automatic check_init_sweep(input string tag);
    int n = 0;
    bit ok = 1'b1;
    for (int i = 0; i < 300 && !bus.init_done; i++) begin
      if (!(bus.sram_en && bus.sram_wmode && bus.sram_wmask &&
            bus.sram_addr == n[7:0] && bus.sram_wdata == INIT_CTR)) ok = 1'b0;
      if (bus.req_ready || bus.upd_ready) ok = 1'b0;
      n++;
      @(negedge clock); #1;
    end
    chk({tag, "_order"}, int'(ok), 1);
    chk({tag, "_writes"}, n, 256);
    chk({tag, "_done"}, int'(bus.init_done), 1);
    chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
  endtask

  task automatic do_lookup(input logic [7:0] idx, output logic [1:0] ctr,
                           output logic tk, output logic vld);
    int n = 0;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_idx   = idx;
    #1;
    while (!bus.req_ready && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    #1;
    vld = bus.resp_valid;
    ctr = bus.resp_ctr;
    tk  = bus.resp_taken;
  endtask

  task automatic do_update(input logic [7:0] idx, input logic tk, input logic fl,
                           output logic [1:0] wd, output logic ok);
    int n = 0;
    @(negedge clock);
    bus.upd_valid = 1'b1;
    bus.upd_idx   = idx;
    bus.upd_taken = tk;
    #1;
    while (!bus.upd_ready && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    @(negedge clock);
    bus.upd_valid = 1'b0;
    bus.flush     = fl;
    #1;
    ok = bus.sram_en && bus.sram_wmode && (bus.sram_addr == idx) &&
         !bus.upd_ready && !bus.req_ready;
    wd = bus.sram_wdata;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] ctr, wd, refv, pend;
    logic       tk, vld, ok;
    bit         pend_v, alt_ok, both_ok, resp_ok;
    int         last, nu, nr, nresp, n;

    vecs[0]  = '{1'b0, 8'h10, 1'b0, 2'b01};
    vecs[1]  = '{1'b1, 8'h10, 1'b1, 2'b10};
    vecs[2]  = '{1'b1, 8'h10, 1'b1, 2'b11};
    vecs[3]  = '{1'b1, 8'h10, 1'b1, 2'b11};
    vecs[4]  = '{1'b0, 8'h10, 1'b0, 2'b11};
    vecs[5]  = '{1'b1, 8'h10, 1'b1, 2'b11};
    vecs[6]  = '{1'b0, 8'h10, 1'b0, 2'b11};
    vecs[7]  = '{1'b1, 8'h20, 1'b0, 2'b00};
    vecs[8]  = '{1'b1, 8'h20, 1'b0, 2'b00};
    vecs[9]  = '{1'b1, 8'h20, 1'b0, 2'b00};
    vecs[10] = '{1'b0, 8'h20, 1'b0, 2'b00};
    vecs[11] = '{1'b1, 8'h30, 1'b1, 2'b10};
    vecs[12] = '{1'b1, 8'h30, 1'b0, 2'b01};
    vecs[13] = '{1'b0, 8'h30, 1'b0, 2'b01};
    vecs[14] = '{1'b0, 8'h31, 1'b0, 2'b01};
    vecs[15] = '{1'b0, 8'hFF, 1'b0, 2'b01};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 2'b01};
    vecs[17] = '{1'b1, 8'h00, 1'b0, 2'b00};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 2'b00};
    vecs[19] = '{1'b0, 8'h10, 1'b0, 2'b11};

    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_idx   = 8'h00;
    bus.upd_valid = 1'b0;
    bus.upd_idx   = 8'h00;
    bus.upd_taken = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_init_done", int'(bus.init_done), 0);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_resp_ctr", int'(bus.resp_ctr), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_upd_ready", int'(bus.upd_ready), 0);
    chk("rst_sram_en", int'(bus.sram_en), 0);
    chk("rst_sram_wmode", int'(bus.sram_wmode), 0);
    chk("rst_sram_wdata", int'(bus.sram_wdata), 0);

    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_init_sweep("init");

    // Table-driven lookups and updates
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_upd) begin
        do_update(vecs[i].idx, vecs[i].tk, 1'b0, wd, ok);
        chk($sformatf("vec%0d_upd_write", i), int'(ok), 1);
        chk($sformatf("vec%0d_upd_data", i), int'(wd), int'(vecs[i].exp));
      end else begin
        do_lookup(vecs[i].idx, ctr, tk, vld);
        chk($sformatf("vec%0d_lk_valid", i), int'(vld), 1);
        chk($sformatf("vec%0d_lk_ctr", i), int'(ctr), int'(vecs[i].exp));
        chk($sformatf("vec%0d_lk_taken", i), int'(tk), int'(vecs[i].exp[1]));
      end
    end

    // Both requesters held high: grants must alternate
    refv = 2'b01; pend = 2'b00; pend_v = 1'b0;
    alt_ok = 1'b1; both_ok = 1'b1; resp_ok = 1'b1;
    last = -1; nu = 0; nr = 0; nresp = 0;
    @(negedge clock);
    bus.upd_valid = 1'b1; bus.upd_idx = 8'h40; bus.upd_taken = 1'b1;
    bus.req_valid = 1'b1; bus.req_idx = 8'h40;
    #1;
    for (int c = 0; c < 16; c++) begin
      if (bus.req_ready && bus.upd_ready) both_ok = 1'b0;
      if (bus.resp_valid) begin
        if (!pend_v || bus.resp_ctr !== pend) resp_ok = 1'b0;
        pend_v = 1'b0;
        nresp++;
      end
      if (bus.upd_ready) begin
        if (last == 0) alt_ok = 1'b0;
        last = 0; nu++;
        refv = ref_next(refv, 1'b1);
      end else if (bus.req_ready) begin
        if (last == 1) alt_ok = 1'b0;
        last = 1; nr++;
        pend = refv; pend_v = 1'b1;
      end
      @(negedge clock); #1;
    end
    bus.upd_valid = 1'b0;
    bus.req_valid = 1'b0;
    if (bus.resp_valid) begin
      if (!pend_v || bus.resp_ctr !== pend) resp_ok = 1'b0;
      pend_v = 1'b0;
      nresp++;
    end
    chk("arb_never_both", int'(both_ok), 1);
    chk("arb_alternate", int'(alt_ok), 1);
    chk("arb_resp_match", int'(resp_ok), 1);
    chk("arb_upd_grants", nu, 6);
    chk("arb_req_grants", nr, 5);
    chk("arb_resp_count", nresp, nr);

    // Lookup in flight when a flush arrives in IDLE, then flush mid-sweep
    n = 0;
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_idx = 8'h10;
    #1;
    while (!bus.req_ready && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b1;
    #1;
    chk("inflight_valid", int'(bus.resp_valid), 1);
    chk("inflight_ctr", int'(bus.resp_ctr), 3);
    chk("inflight_done_hold", int'(bus.init_done), 1);
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    chk("flush_done_drop", int'(bus.init_done), 0);
    chk("flush_resp_gone", int'(bus.resp_valid), 0);
    repeat (5) @(negedge clock);
    bus.flush = 1'b1;
    #1;
    chk("sweep_mid_addr", int'(bus.sram_addr), 5);
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    check_init_sweep("reflush");
    do_lookup(8'h10, ctr, tk, vld);
    chk("reflush_lk_valid", int'(vld), 1);
    chk("reflush_lk_ctr", int'(ctr), 1);

    // Flush during UPD_WR: write completes, then a full sweep
    do_update(8'h50, 1'b1, 1'b1, wd, ok);
    chk("flushwr_write", int'(ok), 1);
    chk("flushwr_data", int'(wd), 2);
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    chk("flushwr_mem", int'(mem[8'h50]), 2);
    chk("flushwr_done_low", int'(bus.init_done), 0);
    check_init_sweep("flushwr");
    do_lookup(8'h50, ctr, tk, vld);
    chk("flushwr_lk50", int'(ctr), 1);
    do_lookup(8'h20, ctr, tk, vld);
    chk("flushwr_lk20", int'(ctr), 1);

    // Reset asserted during UPD_WR: no write may land
    n = 0;
    @(negedge clock);
    bus.upd_valid = 1'b1; bus.upd_idx = 8'h60; bus.upd_taken = 1'b0;
    #1;
    while (!bus.upd_ready && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    @(negedge clock);
    bus.upd_valid = 1'b0;
    #1;
    chk("rstwr_en_before", int'(bus.sram_en), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rstwr_en_now", int'(bus.sram_en), 0);
    chk("rstwr_wmode_now", int'(bus.sram_wmode), 0);
    chk("rstwr_init_done", int'(bus.init_done), 0);
    chk("rstwr_upd_ready", int'(bus.upd_ready), 0);
    repeat (2) @(negedge clock);
    #1;
    chk("rstwr_no_write", int'(mem[8'h60]), 1);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_init_sweep("rstwr");
    do_lookup(8'h60, ctr, tk, vld);
    chk("rstwr_lk60", int'(ctr), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
